// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and Gray/binary helpers for the async FIFO pointer blocks
//
// Purpose: sizing helpers and Gray <-> binary conversion used by the read-side
// and write-side pointer blocks.
// Contents:
//   FIFO_ADDR_WIDTH / DEPTH / PTR_W : default sizing (ADDR_WIDTH = 4)
//   depth_of(aw), ptr_w_of(aw)      : sizing for a given address width
//   bin2gray(b), gray2bin(g)        : 32-bit wide; narrower values are zero-extended
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 4;
  localparam int unsigned DEPTH           = 2 ** FIFO_ADDR_WIDTH;
  localparam int unsigned PTR_W           = FIFO_ADDR_WIDTH + 1;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 2 ** aw;
  endfunction

  // One extra pointer bit distinguishes full from empty.
  function automatic int unsigned ptr_w_of(input int unsigned aw);
    return aw + 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits leave the result unchanged, so any width up to 32 works.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_n.sv
// rtl/gray2bin_n.sv - combinational W-bit Gray-to-binary converter
//
// Purpose: binary value of a Gray-coded pointer.
// Ports:
//   gray_i : W-bit Gray code
//   bin_o  : W-bit binary equivalent
module gray2bin_n #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/rptr_empty_lvl.sv
// rtl/rptr_empty_lvl.sv - async FIFO read-side pointer, empty, almost-empty, level and underflow
//
// Purpose: read-domain pointer and status block for the asynchronous FIFO.
// Ports:
//   rclk            : read-domain clock
//   rrst_n          : synchronous active-low reset
//   r_inc           : pop request
//   r2q_wptr        : Gray write pointer, already synchronised into rclk
//   r_ae_level      : almost-empty threshold in words
//   r_underflow_clr : clears the sticky underflow flag
//   r_empty         : FIFO empty (registered)
//   r_aempty        : level <= r_ae_level (registered)
//   r_level         : words available, 0..DEPTH (registered)
//   r_underflow     : sticky, set by a pop attempted while empty
//   r_add           : memory read address
//   r_ptr           : Gray read pointer passed to the write domain (registered)
module rptr_empty_lvl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  r_inc,
  input  logic [ADDR_WIDTH:0]   r2q_wptr,
  input  logic [ADDR_WIDTH:0]   r_ae_level,
  input  logic                  r_underflow_clr,
  output logic                  r_empty,
  output logic                  r_aempty,
  output logic [ADDR_WIDTH:0]   r_level,
  output logic                  r_underflow,
  output logic [ADDR_WIDTH-1:0] r_add,
  output logic [ADDR_WIDTH:0]   r_ptr
);

  localparam int unsigned PW = ptr_w_of(ADDR_WIDTH);

  // DATA_WIDTH only has to be legal; it keeps the parameter list aligned with the FIFO top.
  if (DATA_WIDTH < 1 || ADDR_WIDTH < 1) begin : g_bad_param
    $error("rptr_empty_lvl: ADDR_WIDTH and DATA_WIDTH must be at least 1");
  end

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          aempty_q, aempty_d;
  logic          uflow_q, uflow_d;
  logic [PW-1:0] wbin;
  logic          pop;

  gray2bin_n #(.W(PW)) u_wptr_g2b (
    .gray_i (r2q_wptr),
    .bin_o  (wbin)
  );

  always_comb begin
    pop      = r_inc & ~empty_q;
    rbin_d   = rbin_q + PW'(pop);
    rptr_d   = PW'(bin2gray(32'(rbin_d)));
    empty_d  = (rptr_d == r2q_wptr);
    // Modulo subtraction keeps the level correct across pointer wrap.
    level_d  = wbin - rbin_d;
    aempty_d = (level_d <= r_ae_level);
    // A pop attempted while empty beats a simultaneous clear.
    uflow_d  = uflow_q;
    if (r_underflow_clr) begin
      uflow_d = 1'b0;
    end
    if (r_inc & empty_q) begin
      uflow_d = 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      uflow_q  <= 1'b0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      uflow_q  <= uflow_d;
    end
  end

  assign r_add       = rbin_q[ADDR_WIDTH-1:0];
  assign r_ptr       = rptr_q;
  assign r_level     = level_q;
  assign r_empty     = empty_q;
  assign r_aempty    = aempty_q;
  assign r_underflow = uflow_q;

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// tb/tb_rptr_empty_lvl.sv - scoreboard bench for rptr_empty_lvl with ADDR_WIDTH=4
module tb_rptr_empty_lvl;

  localparam logic [5:0] ME = 6'd1;   // r_empty
  localparam logic [5:0] MA = 6'd2;   // r_aempty
  localparam logic [5:0] ML = 6'd4;   // r_level
  localparam logic [5:0] MU = 6'd8;   // r_underflow
  localparam logic [5:0] MD = 6'd16;  // r_add
  localparam logic [5:0] MP = 6'd32;  // r_ptr
  localparam logic [5:0] MALL = 6'd63;

  typedef struct {
    int         step;
    logic [5:0] mask;
    logic       rst_edge;
    logic       emp;
    logic       aem;
    logic [4:0] lvl;
    logic       uf;
    logic [3:0] add;
    logic [4:0] ptr;
  } exp_t;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic       r_inc = 1'b0;
  logic [4:0] r2q_wptr = '0;
  logic [4:0] r_ae_level = '0;
  logic       r_underflow_clr = 1'b0;
  logic       r_empty;
  logic       r_aempty;
  logic [4:0] r_level;
  logic       r_underflow;
  logic [3:0] r_add;
  logic [4:0] r_ptr;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  rptr_empty_lvl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .rclk            (rclk),
    .rrst_n          (rrst_n),
    .r_inc           (r_inc),
    .r2q_wptr        (r2q_wptr),
    .r_ae_level      (r_ae_level),
    .r_underflow_clr (r_underflow_clr),
    .r_empty         (r_empty),
    .r_aempty        (r_aempty),
    .r_level         (r_level),
    .r_underflow     (r_underflow),
    .r_add           (r_add),
    .r_ptr           (r_ptr)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string nm, input int st, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, st, act, expv);
    end
  endtask

  // Drive one edge's inputs and queue what the outputs must show after that edge.
  task automatic step(input logic rst_n, input logic inc, input logic [4:0] wptr,
                      input logic [4:0] ae, input logic clr, input logic [5:0] mask,
                      input logic emp, input logic aem, input logic [4:0] lvl,
                      input logic uf, input logic [3:0] add, input logic [4:0] ptr);
    exp_t e;
    @(negedge rclk);
    rrst_n          = rst_n;
    r_inc           = inc;
    r2q_wptr        = wptr;
    r_ae_level      = ae;
    r_underflow_clr = clr;
    step_no++;
    e.step = step_no; e.mask = mask; e.rst_edge = !rst_n;
    e.emp = emp; e.aem = aem; e.lvl = lvl; e.uf = uf; e.add = add; e.ptr = ptr;
    sb.push_back(e);
  endtask

  // Monitor: one scoreboard entry per edge, sampled 1 time unit after the edge.
  initial begin
    exp_t       e;
    logic [4:0] prev_ptr;
    logic       have_prev;
    have_prev = 1'b0;
    prev_ptr  = '0;
    forever begin
      @(posedge rclk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.mask[0]) chk("r_empty",     e.step, int'(r_empty),     int'(e.emp));
        if (e.mask[1]) chk("r_aempty",    e.step, int'(r_aempty),    int'(e.aem));
        if (e.mask[2]) chk("r_level",     e.step, int'(r_level),     int'(e.lvl));
        if (e.mask[3]) chk("r_underflow", e.step, int'(r_underflow), int'(e.uf));
        if (e.mask[4]) chk("r_add",       e.step, int'(r_add),       int'(e.add));
        if (e.mask[5]) chk("r_ptr",       e.step, int'(r_ptr),       int'(e.ptr));
        chk("level_in_range", e.step, int'(r_level <= 5'd16), 1);
        if (have_prev && !e.rst_edge)
          chk("gray_one_bit", e.step, int'($countones(r_ptr ^ prev_ptr) <= 1), 1);
        prev_ptr  = r_ptr;
        have_prev = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, steps issued %0d", step_no);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held two edges while popping; release shows three words.
    step(0, 1, 5'b00010, 5'd0, 0, MALL, 1, 1, 5'd0, 0, 4'd0, 5'b00000);
    step(0, 1, 5'b00010, 5'd0, 0, MALL, 1, 1, 5'd0, 0, 4'd0, 5'b00000);
    step(1, 0, 5'b00010, 5'd0, 0, ME|ML|MA|MU, 0, 0, 5'd3, 0, 4'd0, 5'b00000);

    // Drain five words with almost-empty threshold 2.
    step(0, 0, 5'b00010, 5'd2, 0, ME|MA|ML, 1, 1, 5'd0, 0, 4'd0, 5'b00000);
    step(1, 0, 5'b00111, 5'd2, 0, ME|MA|ML|MD|MP, 0, 0, 5'd5, 0, 4'd0, 5'b00000);
    step(1, 1, 5'b00111, 5'd2, 0, ME|MA|ML|MD|MP, 0, 0, 5'd4, 0, 4'd1, 5'b00001);
    step(1, 1, 5'b00111, 5'd2, 0, ME|MA|ML|MD|MP, 0, 0, 5'd3, 0, 4'd2, 5'b00011);
    step(1, 1, 5'b00111, 5'd2, 0, ME|MA|ML|MD|MP, 0, 1, 5'd2, 0, 4'd3, 5'b00010);
    step(1, 1, 5'b00111, 5'd2, 0, ME|MA|ML|MD|MP, 0, 1, 5'd1, 0, 4'd4, 5'b00110);
    step(1, 1, 5'b00111, 5'd2, 0, ME|MA|ML|MD|MP, 1, 1, 5'd0, 0, 4'd5, 5'b00111);

    // Underflow: set, set beats clear, clear alone.
    step(1, 1, 5'b00111, 5'd2, 0, ME|MU|MD|MP, 1, 1, 5'd0, 1, 4'd5, 5'b00111);
    step(1, 1, 5'b00111, 5'd2, 1, ME|MU|MD|MP, 1, 1, 5'd0, 1, 4'd5, 5'b00111);
    step(1, 0, 5'b00111, 5'd2, 1, ME|MU, 1, 1, 5'd0, 0, 4'd5, 5'b00111);

    // Advance rbin to 30: write pointer to 21 (full), drain, then to 30, drain.
    step(1, 0, 5'b11111, 5'd2, 0, ME|ML, 0, 0, 5'd16, 0, 4'd0, 5'b00000);
    for (int i = 0; i < 16; i++)
      step(1, 1, 5'b11111, 5'd2, 0, (i == 15) ? (ME|ML|MD) : 6'd0, 1, 1, 5'd0, 0, 4'd5, 5'b00000);
    step(1, 0, 5'b10001, 5'd2, 0, ME|ML, 0, 0, 5'd9, 0, 4'd0, 5'b00000);
    for (int i = 0; i < 9; i++)
      step(1, 1, 5'b10001, 5'd2, 0, (i == 8) ? (ME|ML|MD|MP) : 6'd0, 1, 1, 5'd0, 0, 4'd14, 5'b10001);

    // Wrap: write pointer wraps to 3, level 5; pops carry rbin over 31 -> 0.
    step(1, 0, 5'b00010, 5'd2, 0, ME|ML|MP, 0, 0, 5'd5, 0, 4'd0, 5'b10001);
    step(1, 1, 5'b00010, 5'd2, 0, ML|MD|MP, 0, 0, 5'd4, 0, 4'd15, 5'b10000);
    step(1, 1, 5'b00010, 5'd2, 0, ML|MD|MP, 0, 0, 5'd3, 0, 4'd0, 5'b00000);

    // Bring rbin to 7: drain to 3, write pointer to 7, drain again.
    for (int i = 0; i < 3; i++)
      step(1, 1, 5'b00010, 5'd2, 0, (i == 2) ? (ME|ML|MD) : 6'd0, 1, 1, 5'd0, 0, 4'd3, 5'b00000);
    step(1, 0, 5'b00100, 5'd2, 0, ML, 0, 0, 5'd4, 0, 4'd0, 5'b00000);
    for (int i = 0; i < 4; i++)
      step(1, 1, 5'b00100, 5'd2, 0, (i == 3) ? (ME|ML|MD|MP) : 6'd0, 1, 1, 5'd0, 0, 4'd7, 5'b00100);

    // Full: write pointer 23, level 16, threshold 15.
    step(1, 0, 5'b11100, 5'd15, 0, ME|MA|ML, 0, 0, 5'd16, 0, 4'd0, 5'b00000);
    step(1, 1, 5'b11100, 5'd15, 0, ME|MA|ML|MD|MP, 0, 1, 5'd15, 0, 4'd8, 5'b01100);

    // Mid-operation reset at rbin 9 while popping.
    step(1, 1, 5'b11100, 5'd15, 0, ML|MD|MP, 0, 1, 5'd14, 0, 4'd9, 5'b01101);
    step(0, 1, 5'b00000, 5'd15, 0, MALL, 1, 1, 5'd0, 0, 4'd0, 5'b00000);
    step(1, 0, 5'b00000, 5'd15, 0, ME|MA|ML|MU|MP, 1, 1, 5'd0, 0, 4'd0, 5'b00000);

    @(negedge rclk);
    @(negedge rclk);
    chk("scoreboard_drained", step_no, sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
